// File: rtl/reg_share_pkg.sv
// Shared types and width helpers for the register-sharing arbiter.
// Width helpers are functions because the widths depend on module parameters.
package reg_share_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, HOLD, DONE} state_t;

    function automatic int cnt_width(input int settle_cycles);
        return $clog2(settle_cycles + 1);
    endfunction

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set request at or after ptr wins,
// with the search wrapping modulo N.
module rr_priority_picker
    import reg_share_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                idx      = IDX_W'(pos);
                gnt[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin write sequencer for one shared capture register: setup cycle,
// one-cycle load strobe, SETTLE_CYCLES of hold, then an acknowledge.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                       CLK_CI,
    input  logic                       RST_RB,
    input  logic [NUM_REQ-1:0]         Req_SI,
    input  logic [NUM_REQ*WIDTH-1:0]   Data_DI,
    output logic [NUM_REQ-1:0]         Gnt_SO,
    output logic [NUM_REQ-1:0]         Ack_SO,
    output logic                       RegLoad_SO,
    output logic [WIDTH-1:0]           RegData_DO,
    output logic                       Busy_SO
);

    localparam int CNT_W = cnt_width(SETTLE_CYCLES);
    localparam int IDX_W = idx_width(NUM_REQ);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     ptr_reg, ptr_next;
    logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]   ack_reg, ack_next;
    logic                 load_reg, load_next;
    logic [WIDTH-1:0]     data_reg, data_next;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [WIDTH-1:0]     lane_data [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_data[gi] = Data_DI[gi*WIDTH +: WIDTH];
    end

    rr_priority_picker #(.N(NUM_REQ)) u_picker (
        .req   (Req_SI),
        .ptr   (ptr_reg),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Outputs are registered, so each *_next describes the state being entered.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        data_next  = data_reg;
        ack_next   = '0;
        load_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = SETUP;
                    gnt_next   = pick_gnt;
                    data_next  = lane_data[pick_idx];
                    ptr_next   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            SETUP: begin
                state_next = LOAD;
                load_next  = 1'b1;
            end
            LOAD: begin
                state_next = HOLD;
                cnt_next   = CNT_W'(SETTLE_CYCLES);
            end
            HOLD: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                    ack_next   = gnt_reg;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_CI or negedge RST_RB) begin
        if (!RST_RB) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            ack_reg   <= '0;
            load_reg  <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            ack_reg   <= ack_next;
            load_reg  <= load_next;
            data_reg  <= data_next;
        end
    end

    assign Gnt_SO     = gnt_reg;
    assign Ack_SO     = ack_reg;
    assign RegLoad_SO = load_reg;
    assign RegData_DO = data_reg;
    assign Busy_SO    = (state_reg != IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed plus random bench for reg_share_arbiter against a transaction-level
// model that tracks the winner and the cycle offset since the grant edge.
module tb_reg_share_arbiter;

    localparam int WIDTH  = 8;
    localparam int NREQ   = 4;
    localparam int SETTLE = 2;
    localparam int TLAST  = SETTLE + 2;

    logic                   CLK_CI = 1'b0;
    logic                   RST_RB = 1'b1;
    logic [NREQ-1:0]        Req_SI = '0;
    logic [NREQ*WIDTH-1:0]  Data_DI = '0;
    logic [NREQ-1:0]        Gnt_SO;
    logic [NREQ-1:0]        Ack_SO;
    logic                   RegLoad_SO;
    logic [WIDTH-1:0]       RegData_DO;
    logic                   Busy_SO;

    reg_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NREQ), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK_CI     (CLK_CI),
        .RST_RB     (RST_RB),
        .Req_SI     (Req_SI),
        .Data_DI    (Data_DI),
        .Gnt_SO     (Gnt_SO),
        .Ack_SO     (Ack_SO),
        .RegLoad_SO (RegLoad_SO),
        .RegData_DO (RegData_DO),
        .Busy_SO    (Busy_SO)
    );

    always #5 CLK_CI = ~CLK_CI;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit              m_busy;
    int              m_t, m_win, m_ptr;
    logic [WIDTH-1:0] m_data;

    logic [NREQ-1:0] prev_gnt;
    int              grant_who[$];
    int              grant_cyc[$];
    int              load_cnt, ack_off, t0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_t = 0; m_win = 0; m_ptr = 0; m_data = '0;
    endtask

    // Transaction-level view: a grant starts a fixed-length timeline of TLAST+1 cycles.
    task automatic model_edge();
        bit found;
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && Req_SI[(m_ptr + k) % NREQ]) begin
                    found = 1;
                    m_win = (m_ptr + k) % NREQ;
                end
            end
            if (found) begin
                m_busy = 1;
                m_t    = 0;
                m_data = Data_DI[m_win*WIDTH +: WIDTH];
                m_ptr  = (m_win + 1) % NREQ;
            end
        end else if (m_t == TLAST) begin
            m_busy = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] eg;
        eg = m_busy ? NREQ'(1 << m_win) : '0;
        check("gnt",  Gnt_SO, eg);
        check("ack",  Ack_SO, (m_busy && m_t == TLAST) ? eg : '0);
        check("load", RegLoad_SO, (m_busy && m_t == 1));
        check("data", RegData_DO, m_data);
        check("busy", Busy_SO, m_busy);
    endtask

    task automatic tick();
        @(posedge CLK_CI);
        if (RST_RB) model_edge();
        @(negedge CLK_CI);
        cyc++;
        check_outputs();
        if (Gnt_SO != '0 && prev_gnt == '0) begin
            for (int i = 0; i < NREQ; i++) if (Gnt_SO[i]) grant_who.push_back(i);
            grant_cyc.push_back(cyc);
        end
        prev_gnt = Gnt_SO;
        if (RegLoad_SO) load_cnt++;
        $display("cyc %0d req %b gnt %b ack %b load %b data %h busy %b",
                 cyc, Req_SI, Gnt_SO, Ack_SO, RegLoad_SO, RegData_DO, Busy_SO);
    endtask

    // Called at a negedge; asserts reset, checks the immediate clear, releases one cycle later.
    task automatic pulse_reset();
        RST_RB = 1'b0;
        #1;
        model_reset();
        prev_gnt = '0;
        check_outputs();
        @(negedge CLK_CI);
        check_outputs();
        RST_RB = 1'b1;
    endtask

    initial begin
        model_reset();
        prev_gnt = '0;
        #2 RST_RB = 1'b0;
        #1 check_outputs();
        @(negedge CLK_CI);
        RST_RB = 1'b1;

        // Single request on lane 2
        Req_SI = 4'b0100;
        Data_DI[2*WIDTH +: WIDTH] = 8'hA5;
        load_cnt = 0; ack_off = -1;
        tick();
        t0 = cyc;
        check("t1_gnt", Gnt_SO, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Ack_SO != '0 && ack_off < 0) ack_off = cyc - t0;
        end
        Req_SI = '0;
        check("t1_ack_off", ack_off, 4);
        check("t1_loads", load_cnt, 1);
        tick(); tick();

        // Fairness from a fresh reset: all four requesting continuously
        @(negedge CLK_CI);
        pulse_reset();
        grant_who.delete(); grant_cyc.delete();
        for (int i = 0; i < NREQ; i++) Data_DI[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
        Req_SI = 4'b1111;
        for (int i = 0; i < 26; i++) tick();
        Req_SI = '0;
        check("fair_cnt", grant_who.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_who.size()) begin
                check("fair_order", grant_who[i], i % NREQ);
                if (i > 0) check("fair_space", grant_cyc[i] - grant_cyc[i-1], SETTLE + 4);
            end
        end
        for (int i = 0; i < 8; i++) tick();

        // Data change after grant is ignored
        Req_SI = 4'b0001;
        Data_DI[0 +: WIDTH] = 8'h11;
        tick();
        Data_DI[0 +: WIDTH] = 8'h22;
        tick();
        check("t3_load", RegLoad_SO, 1);
        check("t3_cap", RegData_DO, 8'h11);
        tick(); tick(); tick();
        Req_SI = '0;
        tick(); tick();

        // Request withdrawn during SETUP
        Req_SI = 4'b1000;
        Data_DI[3*WIDTH +: WIDTH] = 8'h5A;
        load_cnt = 0; ack_off = -1;
        tick();
        t0 = cyc;
        Req_SI = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Ack_SO != '0 && ack_off < 0) ack_off = cyc - t0;
        end
        check("t4_ack_off", ack_off, 4);
        check("t4_loads", load_cnt, 1);

        // Reset during HOLD, then first grant goes to lowest active index
        Req_SI = 4'b0001;
        tick(); tick(); tick();
        check("t5_busy", Busy_SO, 1);
        Req_SI = 4'b1010;
        pulse_reset();
        tick();
        check("t5_gnt", Gnt_SO, 4'b0010);
        for (int i = 0; i < 4; i++) tick();
        Req_SI = '0;
        tick(); tick();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            Req_SI  = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) Req_SI = '0;
            Data_DI = $urandom();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter and write sequencer that shares one timed capture register between NUM_REQ requesters. It selects one requester, presents its data to the register one full cycle before the load edge (setup margin), and holds it SETTLE_CYCLES after the load edge (hold and propagation margin). It then acknowledges the requester. It sits directly in front of the register's data/load inputs; requesters never drive the register themselves.

## Interface
- WIDTH, 8, data width of each requester and of the shared register
- NUM_REQ, 4, number of requesters (legal 2..16)
- SETTLE_CYCLES, 2, cycles data stays driven after the load pulse (legal >= 1)
- CLK_CI  in  1  clock, rising edge
- RST_RB  in  1  asynchronous, active-low reset
- Req_SI  in  NUM_REQ  per-requester write request, level
- Data_DI  in  NUM_REQ*WIDTH  packed request data; requester i occupies bits [i*WIDTH +: WIDTH]
- Gnt_SO  out  NUM_REQ  one-hot grant, registered
- Ack_SO  out  NUM_REQ  one-cycle completion pulse to the granted requester, registered
- RegLoad_SO  out  1  load strobe to shared register
- RegData_DO  out  WIDTH  data to shared register, registered
- Busy_SO  out  1  high whenever state != IDLE

## Operation
- The FSM has five states: IDLE -> SETUP -> LOAD -> HOLD -> DONE -> IDLE.
- IDLE
  - Req_SI is sampled on every edge.
  - If any bit is set, the winner is chosen round-robin.
  - On that edge the arbiter registers Gnt_SO and latches the winner's Data_DI into RegData_DO, then moves to SETUP.
- SETUP: lasts 1 cycle. RegData_DO is stable and RegLoad_SO = 0.
- LOAD: lasts 1 cycle. RegLoad_SO = 1, so the register captures on the edge that ends LOAD.
- HOLD
  - Lasts exactly SETTLE_CYCLES cycles, counted by a down-counter loaded at LOAD exit.
  - RegData_DO is unchanged and RegLoad_SO = 0.
- DONE
  - Lasts 1 cycle, with Ack_SO[granted] = 1 and Gnt_SO still asserted.
  - The edge ending DONE clears Gnt_SO and returns to IDLE.
- Round-robin rule
  - Priority search starts at pointer P and wraps modulo NUM_REQ. The first set Req bit wins.
  - P is updated to (winner+1) mod NUM_REQ when the grant is registered.
- Data handling
  - Data is latched at grant; requester data changes after the grant edge are ignored.
  - If Req drops after grant, the transaction still completes and the Ack is still issued.
- Request sampling
  - Req_SI is sampled only in IDLE.
  - Requesters deassert Req on the edge ending their Ack cycle. A Req still high in IDLE is treated as a new request.
- RegData_DO is retained at its last value in IDLE. The register only samples on RegLoad_SO.

## Timing
- Reset (asynchronous, immediate) values:
  - state IDLE, P = 0, counter 0
  - Gnt_SO = 0, Ack_SO = 0, RegLoad_SO = 0, RegData_DO = 0, Busy_SO = 0
- Reset mid-transaction aborts with no Ack and no further RegLoad pulse. The first grant after reset release goes to the lowest-index active requester.
- Latency, with edge 0 = grant edge:
  - SETUP is cycle 0, LOAD is cycle 1, HOLD is cycles 2..SETTLE_CYCLES+1.
  - DONE is cycle SETTLE_CYCLES+2, where Ack_SO is high.
  - Capture edge = edge 2.
- Throughput: at most one transaction per SETTLE_CYCLES+4 cycles (IDLE is always visited).
- Data stability: RegData_DO is stable from edge 0 through the edge ending DONE.
  - That gives 1 full cycle before capture and SETTLE_CYCLES cycles after capture.
- Output invariants:
  - Gnt_SO and Ack_SO are always one-hot or zero.
  - Ack_SO is a subset of Gnt_SO.
  - RegLoad_SO is high for exactly one cycle per transaction.
- Simultaneous requests in IDLE are resolved purely by P; no request waits more than NUM_REQ-1 transactions.

## Structure
- Package reg_share_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, SETUP, LOAD, HOLD, DONE}
  - localparam-style helpers: CNT_W = $clog2(SETTLE_CYCLES+1) and IDX_W = $clog2(NUM_REQ)
- Sub-module rr_priority_picker (parameter N) is combinational.
  - Inputs: req[N-1:0] and ptr[IDX_W-1:0].
  - Outputs: one-hot grant, winner index and valid.
- The remaining logic is the top-level FSM, counter, pointer and data/grant registers.

## Test plan
- Single request: reset, Req_SI = 4'b0100, Data_DI lane2 = 8'hA5.
  - Gnt_SO = 4'b0100 from edge 0 and RegLoad_SO = 1 only in cycle 1.
  - RegData_DO = 8'hA5 in cycles 0..4, Ack_SO = 4'b0100 in cycle 4 only.
- Round-robin fairness: all four requests held high continuously, re-raised after each Ack. Grant order is 0,1,2,3,0, with 6-cycle spacing between grants.
- Data change after grant: lane0 changes from 8'h11 to 8'h22 one cycle after grant. RegData_DO stays 8'h11 and the register captures 8'h11.
- Request withdrawn: Req deasserted in SETUP. The transaction still completes, with one RegLoad pulse and Ack in cycle 4.
- Reset mid-operation: RST_RB pulsed low during HOLD.
  - All outputs go to 0 immediately and no Ack is issued.
  - After release, with Req = 4'b1010, the grant goes to requester 1.
- SETTLE_CYCLES = 1 build: Ack appears in cycle 3 and the next grant can occur no earlier than 5 cycles after the previous one.
